mips_mc_controller: RTL and testbench
=====================================

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 Parameter: SUPPORT_ADDI, default 1, meaning: when 1, decode opcode 001000 (addi); when 0, treat it as illegal.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset, asynchronous and active-low; state forced to FETCH immediately on reset_n=0.
REQ-004 op  input  6  instr[31:26] from the instruction register.
REQ-005 funct  input  6  instr[5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 pcen  output  1  PC register enable, equal to pcwrite OR (branch AND zero).
REQ-008 irwrite  output  1  instruction register load.
REQ-009 iord  output  1  memory address select: 0=pc, 1=aluout.
REQ-010 memwrite  output  1  data memory write strobe.
REQ-011 regwrite, memtoreg, regdst, alusrca  output  1 each  datapath selects and enables.
REQ-012 alusrcb  output  2  00=rd2, 01=4, 10=signimm, 11=signimmsh.
REQ-013 pcsrc  output  2  00=aluresult, 01=aluout, 10=jump target.
REQ-014 alucont  output  3  010=add, 110=sub, 000=and, 001=or, 111=slt.
REQ-015 state  output  4  current state encoding, for debug.

Function
REQ-016 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; codes 12-15 go to FETCH on the next edge.
REQ-017 FETCH: iord=0, alusrca=0, alusrcb=01, alucont=010, pcsrc=00, irwrite=1, pcwrite=1; next state DECODE.
REQ-018 DECODE: alusrca=0, alusrcb=11, alucont=010 (branch target latched into aluout); next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX (when SUPPORT_ADDI=1)
  - 000010 -> JEX
  - any other op -> FETCH (illegal opcode; no writes).
REQ-019 MEMADR: alusrca=1, alusrcb=10, alucont=010; next state MEMRD if op=100011, else MEMWR.
REQ-020 MEMRD: iord=1; next state MEMWB.
REQ-021 MEMWB: regdst=0, memtoreg=1, regwrite=1; next state FETCH.
REQ-022 MEMWR: iord=1, memwrite=1; next state FETCH.
REQ-023 RTYPEEX: alusrca=1, alusrcb=00, alucont decoded from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010
  Next state RTYPEWB.
REQ-024 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; next state FETCH.
REQ-025 BEQEX: alusrca=1, alusrcb=00, alucont=110, pcsrc=01, branch=1; pcen=zero, combinational in the same cycle; next state FETCH.
REQ-026 ADDIEX: alusrca=1, alusrcb=10, alucont=010; next state ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; next state FETCH.
REQ-027 JEX: pcsrc=10, pcwrite=1; next state FETCH.
REQ-028 Every output not listed for a state is 0; alusrcb, pcsrc and alucont are 0 where unlisted, except alucont=010 where REQ-017 to REQ-026 specify it.
REQ-029 All outputs are Moore functions of state, except pcen (depends on zero) and alucont in RTYPEEX (depends on funct).
REQ-030 Instruction cycle counts: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3, illegal=2.

Reset
REQ-031 While reset_n=0: state=FETCH, and pcen, irwrite, memwrite and regwrite are forced to 0; all other outputs take their FETCH values.
REQ-032 On the first posedge after reset_n rises, the controller performs the FETCH actions and moves to DECODE.
REQ-033 reset_n falling in any state aborts the instruction at once: no write enable is asserted after the falling edge, and the next instruction starts at FETCH.

Verification
REQ-034 lw (op=100011) -> state sequence 0,1,2,3,4,0; memtoreg=1 and regwrite=1 only in MEMWB; irwrite=1 only in FETCH.
REQ-035 R-type (op=0) with funct=100010, then with funct=101010 -> alucont=110, then 111, in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB.
REQ-036 beq (op=000100) with zero=1 -> pcen=1, pcsrc=01 in BEQEX; repeat with zero=0 -> pcen=0; both return to FETCH after 3 cycles.
REQ-037 sw then j -> memwrite=1 only in MEMWR, with iord=1; in JEX pcsrc=10 and pcen=1; sequences 0,1,2,5,0 and 0,1,11,0.
REQ-038 Illegal op=111111 -> DECODE goes to FETCH with no regwrite or memwrite; repeat with SUPPORT_ADDI=0 and op=001000 -> same behaviour.
REQ-039 Assert reset_n=0 mid-MEMWB -> state=0 and regwrite=0 immediately; after release, the next instruction completes normally.

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: state register plus Moore decode of datapath controls.
// pcen and the R-type alucont are the only outputs that also look at inputs.
module mips_mc_controller #(
    parameter int unsigned SUPPORT_ADDI = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucont,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d  = FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        alucont  = 3'b000;
        pcen     = 1'b0;

        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                alucont = 3'b010;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                alucont = 3'b010;
                case (op)
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000000:            state_d = RTYPEEX;
                    6'b000100:            state_d = BEQEX;
                    6'b001000:            if (SUPPORT_ADDI != 0) state_d = ADDIEX;
                    6'b000010:            state_d = JEX;
                    default:              state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alucont = 3'b010;
                state_d = (op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucont = 3'b110;
                    6'b100100: alucont = 3'b000;
                    6'b100101: alucont = 3'b001;
                    6'b101010: alucont = 3'b111;
                    default:   alucont = 3'b010;
                endcase
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                alucont = 3'b110;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alucont = 3'b010;
                state_d = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        pcen = pcwrite | (branch & zero);

        // Reset holds FETCH decode but must not let any enable reach the datapath.
        if (!reset_n) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized bench for mips_mc_controller against an instruction-level reference model.
// Two instances cover SUPPORT_ADDI=1 and SUPPORT_ADDI=0; each is exercised while the other is held in reset.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       rst0;
    logic       rst1;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pcen0, irwrite0, iord0, memwrite0, regwrite0, memtoreg0, regdst0, alusrca0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [2:0] alucont0;
    logic [3:0] state0;
    logic       pcen1, irwrite1, iord1, memwrite1, regwrite1, memtoreg1, regdst1, alusrca1;
    logic [1:0] alusrcb1, pcsrc1;
    logic [2:0] alucont1;
    logic [3:0] state1;

    logic [18:0] act0, act1;

    int checks   = 0;
    int failures = 0;
    int seq[$];

    always #5 clk = ~clk;

    mips_mc_controller dut0 (
        .clk(clk), .reset_n(rst0), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen0), .irwrite(irwrite0), .iord(iord0), .memwrite(memwrite0),
        .regwrite(regwrite0), .memtoreg(memtoreg0), .regdst(regdst0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucont(alucont0), .state(state0)
    );

    mips_mc_controller #(.SUPPORT_ADDI(0)) dut1 (
        .clk(clk), .reset_n(rst1), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen1), .irwrite(irwrite1), .iord(iord1), .memwrite(memwrite1),
        .regwrite(regwrite1), .memtoreg(memtoreg1), .regdst(regdst1), .alusrca(alusrca1),
        .alusrcb(alusrcb1), .pcsrc(pcsrc1), .alucont(alucont1), .state(state1)
    );

    assign act0 = {pcen0, irwrite0, iord0, memwrite0, regwrite0, memtoreg0, regdst0, alusrca0,
                   alusrcb0, pcsrc0, alucont0, state0};
    assign act1 = {pcen1, irwrite1, iord1, memwrite1, regwrite1, memtoreg1, regdst1, alusrca1,
                   alusrcb1, pcsrc1, alucont1, state1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Control word expected in a given step of an instruction, in the packing used for act0/act1.
    function automatic logic [18:0] model(input int st, input logic [5:0] fn, input logic z, input bit in_rst);
        logic       pcw, br, irw, io, mw, rw, mtr, rd, asa;
        logic [1:0] asb, ps;
        logic [2:0] ac;
        int         s;
        s = in_rst ? 0 : st;
        {pcw, br, irw, io, mw, rw, mtr, rd, asa} = '0;
        asb = 2'b00; ps = 2'b00; ac = 3'b000;
        case (s)
            0:  begin pcw = 1; irw = 1; asb = 2'b01; ac = 3'b010; end
            1:  begin asb = 2'b11; ac = 3'b010; end
            2:  begin asa = 1; asb = 2'b10; ac = 3'b010; end
            3:  io = 1;
            4:  begin mtr = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin
                    asa = 1;
                    if      (fn == 6'b100010) ac = 3'b110;
                    else if (fn == 6'b100100) ac = 3'b000;
                    else if (fn == 6'b100101) ac = 3'b001;
                    else if (fn == 6'b101010) ac = 3'b111;
                    else                      ac = 3'b010;
                end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; ac = 3'b110; ps = 2'b01; br = 1; end
            9:  begin asa = 1; asb = 2'b10; ac = 3'b010; end
            10: rw = 1;
            11: begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (in_rst) begin
            pcw = 0; br = 0; irw = 0; mw = 0; rw = 0;
        end
        return {pcw | (br & z), irw, io, mw, rw, mtr, rd, asa, asb, ps, ac, 4'(s)};
    endfunction

    // Architectural step sequence for one instruction, by opcode class.
    task automatic build_seq(input logic [5:0] o, input bit addi_ok);
        seq = {0, 1};
        if      (o == 6'b100011)            seq = {0, 1, 2, 3, 4};
        else if (o == 6'b101011)            seq = {0, 1, 2, 5};
        else if (o == 6'b000000)            seq = {0, 1, 6, 7};
        else if (o == 6'b000100)            seq = {0, 1, 8};
        else if (o == 6'b000010)            seq = {0, 1, 11};
        else if (o == 6'b001000 && addi_ok) seq = {0, 1, 9, 10};
    endtask

    // zmode: 0/1 hold zero at that value, 2 randomizes it every cycle.
    task automatic run_instr(input bit which, input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input bit abort_memwb);
        logic [18:0] a;
        build_seq(o, which == 1'b0);
        op    = o;
        funct = f;
        foreach (seq[i]) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            a = which ? act1 : act0;
            check($sformatf("d%0d_op%02h_fn%02h_z%0d_step%0d_st%0d", which, o, f, zero, i, seq[i]),
                  32'(a), 32'(model(seq[i], f, zero, 1'b0)));
            if (abort_memwb && seq[i] == 4) begin
                if (which) rst1 = 1'b0; else rst0 = 1'b0;
                #1;
                a = which ? act1 : act0;
                check("abort_immediate", 32'(a), 32'(model(0, f, zero, 1'b1)));
                @(posedge clk);
                #2;
                a = which ? act1 : act0;
                check("abort_held", 32'(a), 32'(model(0, f, zero, 1'b1)));
                @(negedge clk);
                if (which) rst1 = 1'b1; else rst0 = 1'b1;
                return;
            end
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 6))
            0: return 6'b100011;
            1: return 6'b101011;
            2: return 6'b000000;
            3: return 6'b000100;
            4: return 6'b001000;
            5: return 6'b000010;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 5))
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            4: return 6'b101010;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        op = '0; funct = '0; zero = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_d0", 32'(act0), 32'(model(0, funct, zero, 1'b1)));
        check("reset_d1", 32'(act1), 32'(model(0, funct, zero, 1'b1)));
        @(negedge clk);
        rst0 = 1'b1;

        run_instr(0, 6'b100011, 6'h00, 2, 0);
        run_instr(0, 6'b000000, 6'b100010, 2, 0);
        run_instr(0, 6'b000000, 6'b101010, 2, 0);
        run_instr(0, 6'b000100, 6'h00, 1, 0);
        run_instr(0, 6'b000100, 6'h00, 0, 0);
        run_instr(0, 6'b101011, 6'h00, 2, 0);
        run_instr(0, 6'b000010, 6'h00, 2, 0);
        run_instr(0, 6'b111111, 6'h00, 2, 0);
        run_instr(0, 6'b001000, 6'h00, 2, 0);
        run_instr(0, 6'b100011, 6'h00, 2, 1);
        run_instr(0, 6'b101011, 6'h00, 2, 0);
        for (int n = 0; n < 60; n++)
            run_instr(0, pick_op(), pick_funct(), 2, 0);
        #1;
        check("d0_end_fetch", 32'(state0), 32'd0);

        rst0 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        run_instr(1, 6'b001000, 6'h00, 2, 0);
        run_instr(1, 6'b100011, 6'h00, 2, 0);
        run_instr(1, 6'b111111, 6'h00, 2, 0);
        for (int n = 0; n < 30; n++)
            run_instr(1, pick_op(), pick_funct(), 2, 0);
        #1;
        check("d1_end_fetch", 32'(state1), 32'd0);
        check("d0_held_in_reset", 32'(act0), 32'(model(0, funct, zero, 1'b1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
